fft_reorder: RTL and testbench

- Downstream neighbour of the fft core, fed by its 34-bit serial result stream (17-bit real in [33:17], 17-bit imag in [16:0]).
- The fft core emits each frame in bit-reversed index order; this block buffers each frame in a ping-pong buffer and replays it in natural index order.
- Valid/ready handshake on both sides lets the downstream sink stall without losing frames.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/fft_reorder_bank.sv | 28 ++
 rtl/fft_reorder.sv | 131 +++++++++++++
 tb/tb_fft_reorder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the fft datapath: default sizes, complex sample layout
// and a bit-reversal helper.
package fft_pkg;

    localparam int unsigned FFT_DW  = 34;
    localparam int unsigned FFT_N   = 16;
    localparam int unsigned FFT_AW  = 4;
    localparam int unsigned REV_MAX = 16;

    typedef struct packed {
        logic signed [FFT_DW/2-1:0] re;
        logic signed [FFT_DW/2-1:0] im;
    } fft_sample_t;

    // Reverse the low aw bits of x; bits at and above aw come back as zero.
    function automatic logic [REV_MAX-1:0] bitrev(input logic [REV_MAX-1:0] x,
                                                  input int unsigned aw);
        logic [REV_MAX-1:0] r;
        logic [REV_MAX-1:0] y;
        r = '0;
        y = x;
        for (int unsigned i = 0; i < REV_MAX; i++) begin
            if (i < aw) begin
                r = {r[REV_MAX-2:0], y[0]};
                y = y >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N x DW register bank: synchronous write port, combinational read port.
module fft_reorder_bank
    import fft_pkg::*;
#(
    parameter int unsigned DW = FFT_DW,
    parameter int unsigned N  = FFT_N,
    parameter int unsigned AW = FFT_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [N];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer: writes bit-reversed fft frames, replays them in natural order.
// Optional overflow flag port ovf_sticky is enabled by defining FFT_REORDER_OVF_EN.
module fft_reorder
    import fft_pkg::*;
#(
    parameter int unsigned DW = FFT_DW,
    parameter int unsigned N  = FFT_N
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          out_first,
    output logic          out_last
`ifdef FFT_REORDER_OVF_EN
    ,
    output logic          ovf_sticky
`endif
);

    localparam int unsigned AW = $clog2(N);

    logic          wr_bank;
    logic          rd_bank;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic [1:0]    bank_full;

    logic          wr_fire;
    logic          wr_wrap;
    logic          rd_load;
    logic          rd_wrap;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] rd_data0;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data;
    logic [1:0]    bank_full_nxt;
    logic          wr_bank_nxt;

    assign wr_fire = in_valid && in_ready;
    assign wr_wrap = (wr_cnt == AW'(N - 1));
    assign rd_load = (!out_valid || out_ready) && bank_full[rd_bank];
    assign rd_wrap = (rd_cnt == AW'(N - 1));
    assign wr_addr = AW'(bitrev(REV_MAX'(wr_cnt), AW));
    assign rd_data = rd_bank ? rd_data1 : rd_data0;

    fft_reorder_bank #(.DW(DW), .N(N), .AW(AW)) u_bank0 (
        .clk   (clk),
        .we    (wr_fire && !wr_bank),
        .waddr (wr_addr),
        .wdata (in_data),
        .raddr (rd_cnt),
        .rdata (rd_data0)
    );

    fft_reorder_bank #(.DW(DW), .N(N), .AW(AW)) u_bank1 (
        .clk   (clk),
        .we    (wr_fire && wr_bank),
        .waddr (wr_addr),
        .wdata (in_data),
        .raddr (rd_cnt),
        .rdata (rd_data1)
    );

    // Write side fills a bank, read side frees one; they never target the same bank.
    always_comb begin
        bank_full_nxt = bank_full;
        wr_bank_nxt   = wr_bank;
        if (wr_fire && wr_wrap) begin
            bank_full_nxt[wr_bank] = 1'b1;
            wr_bank_nxt            = !wr_bank;
        end
        if (rd_load && rd_wrap) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            wr_cnt    <= '0;
            bank_full <= '0;
            in_ready  <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + AW'(1);
            end
            wr_bank   <= wr_bank_nxt;
            bank_full <= bank_full_nxt;
            in_ready  <= !bank_full_nxt[wr_bank_nxt];
        end
    end

    // Output register: refills whenever it is empty or being consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (rd_load) begin
            out_data  <= rd_data;
            out_first <= (rd_cnt == '0);
            out_last  <= rd_wrap;
            out_valid <= 1'b1;
            rd_cnt    <= rd_cnt + AW'(1);
            if (rd_wrap) begin
                rd_bank <= !rd_bank;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FFT_REORDER_OVF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (in_valid && !in_ready) begin
            ovf_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder against a frame-level bit-reversal model.
module tb_fft_reorder;

    localparam int unsigned DW = 34;
    localparam int unsigned N  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          out_first;
    logic          out_last;
`ifdef FFT_REORDER_OVF_EN
    logic          ovf_sticky;
`endif

    fft_reorder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last)
`ifdef FFT_REORDER_OVF_EN
        ,
        .ovf_sticky(ovf_sticky)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          f;
        logic          l;
    } exp_t;

    int            total = 0;
    int            bad   = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] frm[N];
    int            frm_cnt = 0;
    int            acc_cnt = 0;
    int            out_cnt = 0;
    int            run_len = 0;
    int            max_run = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_f;
    logic          prev_l;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rev4(input int k);
        int r = 0;
        for (int i = 0; i < 4; i++) r = r * 2 + ((k >> i) & 1);
        return r;
    endfunction

    // Frame model: natural index i of a frame is the sample that arrived at position rev(i).
    task automatic model_push(input logic [DW-1:0] d);
        frm[frm_cnt] = d;
        frm_cnt++;
        if (frm_cnt == N) begin
            for (int i = 0; i < N; i++)
                exp_q.push_back('{d: frm[rev4(i)], f: (i == 0), l: (i == N - 1)});
            frm_cnt = 0;
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (stall_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(prev_d));
            chk("hold_first", 64'(out_first), 64'(prev_f));
            chk("hold_last", 64'(out_last), 64'(prev_l));
        end
        if (in_valid && in_ready) begin
            model_push(in_data);
            acc_cnt++;
        end
        if (out_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (out_valid && out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                chk("extra_out", 64'(out_data), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("data", 64'(out_data), 64'(e.d));
                chk("first", 64'(out_first), 64'(e.f));
                chk("last", 64'(out_last), 64'(e.l));
            end
        end
        stall_prev = out_valid && !out_ready;
        prev_d = out_data;
        prev_f = out_first;
        prev_l = out_last;
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] id, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_first", 64'(out_first), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
`ifdef FFT_REORDER_OVF_EN
        chk("rst_ovf", 64'(ovf_sticky), 64'd0);
`endif
        exp_q.delete();
        frm_cnt    = 0;
        stall_prev = 1'b0;
        run_len    = 0;
    endtask

    function automatic logic [DW-1:0] rnd34();
        return {2'($urandom_range(0, 3)), 32'($urandom)};
    endfunction

    initial begin
        int guard;
        do_reset();

        // Single frame, counting values, out_ready high; also checks first-output latency.
        for (int k = 0; k < N; k++) drive(1'b1, DW'(k), 1'b1);
        chk("lat_pre", 64'(out_valid), 64'd0);
        drive(1'b0, '0, 1'b1);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_first", 64'(out_first), 64'd1);
        chk("lat_data0", 64'(out_data), 64'd0);
        drive(1'b0, '0, 1'b1);
        chk("lat_data1", 64'(out_data), 64'd8);
        for (int k = 0; k < 20; k++) drive(1'b0, '0, 1'b1);
        chk("single_drain", 64'(exp_q.size()), 64'd0);

        // Round trip: bit-reversed input indices come back in natural order.
        for (int k = 0; k < N; k++) drive(1'b1, DW'(rev4(k)), 1'b1);
        for (int k = 0; k < 20; k++) drive(1'b0, '0, 1'b1);
        chk("rt_drain", 64'(exp_q.size()), 64'd0);

        // Back-to-back frames: in_ready must stay high, output a single 48-cycle run.
        max_run = 0;
        out_cnt = 0;
        for (int k = 0; k < 3 * N; k++) begin
            chk("b2b_rdy", 64'(in_ready), 64'd1);
            drive(1'b1, rnd34(), 1'b1);
        end
        for (int k = 0; k < 40; k++) drive(1'b0, '0, 1'b1);
        chk("b2b_run", 64'(max_run), 64'd48);
        chk("b2b_count", 64'(out_cnt), 64'd48);
        chk("b2b_drain", 64'(exp_q.size()), 64'd0);

        // Backpressure: both banks fill, the 33rd sample is dropped.
        acc_cnt = 0;
        out_cnt = 0;
        for (int k = 0; k < 2 * N + 1; k++) begin
            drive(1'b1, DW'(200 + k), 1'b0);
            if (k == 2 * N - 1) chk("bp_rdy_low", 64'(in_ready), 64'd0);
        end
        chk("bp_acc", 64'(acc_cnt), 64'd32);
`ifdef FFT_REORDER_OVF_EN
        chk("bp_ovf", 64'(ovf_sticky), 64'd1);
`endif
        for (int k = 0; k < 10; k++) drive(1'b0, '0, 1'b0);
        for (int k = 0; k < 40; k++) drive(1'b0, '0, 1'b1);
        chk("bp_count", 64'(out_cnt), 64'd32);
        chk("bp_drain", 64'(exp_q.size()), 64'd0);
        chk("bp_rdy_back", 64'(in_ready), 64'd1);

        // Random valid/ready over 10 frames.
        acc_cnt = 0;
        out_cnt = 0;
        guard   = 0;
        while (acc_cnt < 10 * N && guard < 4000) begin
            drive(1'($urandom_range(0, 9) < 8), rnd34(), 1'($urandom_range(0, 1)));
            guard++;
        end
        if (acc_cnt < 10 * N) chk("rand_timeout", 64'(acc_cnt), 64'(10 * N));
        for (int k = 0; k < 80; k++) drive(1'b0, '0, 1'b1);
        chk("rand_count", 64'(out_cnt), 64'(10 * N));
        chk("rand_drain", 64'(exp_q.size()), 64'd0);

        // Reset mid-frame: the partial frame must never appear.
        for (int k = 0; k < 7; k++) drive(1'b1, DW'(50 + k), 1'b1);
        do_reset();
        out_cnt = 0;
        for (int k = 0; k < N; k++) drive(1'b1, DW'(100 + k), 1'b1);
        drive(1'b0, '0, 1'b1);
        chk("mid_first_data", 64'(out_data), 64'd100);
        for (int k = 0; k < 25; k++) drive(1'b0, '0, 1'b1);
        chk("mid_count", 64'(out_cnt), 64'd16);
        chk("mid_drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
